// File: rtl/queue_reader.sv
`default_nettype none
// ============================================================================
// Module   : queue_reader
// Purpose  : Dequeue-side consumer of the 8-entry byte queue. Waits for the
//            queue to hold at least THRESHOLD entries, issues a one-cycle
//            dequeue request, captures the returned byte and presents it
//            downstream on a valid/ready handshake. After each completed
//            handshake it stays idle for at least GAP_CYCLES cycles.
// Revision : 1.0 - initial release
// ============================================================================
module queue_reader #(
  parameter int DATA_W     = 8,
  parameter int LEN_W      = 4,
  parameter int THRESHOLD  = 1,
  parameter int GAP_CYCLES = 0,
  parameter int CNT_W      = 8
) (
  input  logic              clk_10khz,
  input  logic              reset_n,
  input  logic              enable,
  input  logic [LEN_W-1:0]  len_in,
  input  logic [DATA_W-1:0] data_in,
  output logic              dequeue_out,
  output logic [DATA_W-1:0] data_out,
  output logic              valid_out,
  input  logic              ready_in,
  output logic              busy_out,
  output logic [CNT_W-1:0]  pop_count_out
);

  // Gap counter is kept at least one bit wide so GAP_CYCLES=0 still builds.
  localparam int c_GAP_W = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam logic [c_GAP_W-1:0] c_GAP_LOAD = c_GAP_W'(GAP_CYCLES);
  localparam logic [LEN_W-1:0]   c_THRESH   = LEN_W'(THRESHOLD);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_POP     = 2'd1,
    S_LATCH   = 2'd2,
    S_PRESENT = 2'd3
  } state_t;

  state_t               r_state;
  state_t               w_next;
  logic [DATA_W-1:0]    r_data;
  logic [CNT_W-1:0]     r_count;
  logic [c_GAP_W-1:0]   r_gap;
  logic                 w_handshake;
  logic                 w_gap_busy;

  assign w_handshake = (r_state == S_PRESENT) && ready_in;
  assign w_gap_busy  = (r_gap != '0);

  // State register.
  always_ff @(posedge clk_10khz or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic; the queue length is only looked at while idle.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (!w_gap_busy && enable && (len_in >= c_THRESH)) begin
          w_next = S_POP;
        end
      end
      S_POP: begin
        // A pop against an empty queue returns nothing, so skip the capture.
        if (len_in == '0) begin
          w_next = S_IDLE;
        end else begin
          w_next = S_LATCH;
        end
      end
      S_LATCH:   w_next = S_PRESENT;
      S_PRESENT: begin
        if (ready_in) begin
          w_next = S_IDLE;
        end
      end
      default:   w_next = S_IDLE;
    endcase
  end

  // Byte capture, handshake counter and post-handshake idle gap.
  always_ff @(posedge clk_10khz or negedge reset_n) begin
    if (!reset_n) begin
      r_data  <= '0;
      r_count <= '0;
      r_gap   <= '0;
    end else begin
      if (r_state == S_LATCH) begin
        r_data <= data_in;
      end
      if (w_handshake) begin
        r_count <= r_count + 1'b1;
        r_gap   <= c_GAP_LOAD;
      end else if ((r_state == S_IDLE) && w_gap_busy) begin
        r_gap <= r_gap - 1'b1;
      end
    end
  end

  // Moore outputs decoded straight from the state register.
  assign dequeue_out   = (r_state == S_POP);
  assign valid_out     = (r_state == S_PRESENT);
  assign busy_out      = (r_state != S_IDLE);
  assign data_out      = r_data;
  assign pop_count_out = r_count;

endmodule
`default_nettype wire

// File: tb/tb_queue_reader.sv
`default_nettype none
// ============================================================================
// Module   : tb_queue_reader
// Purpose  : Directed self-checking bench for queue_reader. A small queue
//            model feeds the main instance; two extra instances cover the
//            fill threshold and the post-handshake idle gap.
// Revision : 1.0 - initial release
// ============================================================================
module tb_queue_reader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset_n;
  logic       enable;
  logic       ready_in;

  // Main instance (THRESHOLD=1, GAP_CYCLES=0) with queue model.
  logic [3:0] q_len  = 4'd0;
  logic [7:0] q_dout = 8'hEE;
  logic       deq0, vld0, busy0;
  logic [7:0] dout0, cnt0;

  // Threshold instance (THRESHOLD=4).
  logic [3:0] len_t;
  logic       deq_t, vld_t, busy_t;
  logic [7:0] dout_t, cnt_t;

  // Gap instance (GAP_CYCLES=3).
  logic [3:0] len_g;
  logic       deq_g, vld_g, busy_g;
  logic [7:0] dout_g, cnt_g;

  logic [7:0] data_c = 8'h00;

  queue_reader #(.DATA_W(8), .LEN_W(4), .THRESHOLD(1), .GAP_CYCLES(0), .CNT_W(8)) u_dut (
    .clk_10khz(clk), .reset_n(reset_n), .enable(enable), .len_in(q_len),
    .data_in(q_dout), .dequeue_out(deq0), .data_out(dout0), .valid_out(vld0),
    .ready_in(ready_in), .busy_out(busy0), .pop_count_out(cnt0)
  );

  queue_reader #(.DATA_W(8), .LEN_W(4), .THRESHOLD(4), .GAP_CYCLES(0), .CNT_W(8)) u_dut_thr (
    .clk_10khz(clk), .reset_n(reset_n), .enable(enable), .len_in(len_t),
    .data_in(data_c), .dequeue_out(deq_t), .data_out(dout_t), .valid_out(vld_t),
    .ready_in(ready_in), .busy_out(busy_t), .pop_count_out(cnt_t)
  );

  queue_reader #(.DATA_W(8), .LEN_W(4), .THRESHOLD(1), .GAP_CYCLES(3), .CNT_W(8)) u_dut_gap (
    .clk_10khz(clk), .reset_n(reset_n), .enable(enable), .len_in(len_g),
    .data_in(data_c), .dequeue_out(deq_g), .data_out(dout_g), .valid_out(vld_g),
    .ready_in(ready_in), .busy_out(busy_g), .pop_count_out(cnt_g)
  );

  // Queue model: registered removed-data output, length drops after a dequeue.
  logic [7:0] q_mem [8];
  logic [7:0] q_vals [8];
  logic [2:0] q_rd = 3'd0;
  logic       q_load;
  logic [3:0] q_load_n;

  always @(posedge clk) begin
    if (q_load) begin
      q_mem <= q_vals;
      q_rd  <= 3'd0;
      q_len <= q_load_n;
    end else if (deq0 && q_len != 4'd0) begin
      q_dout <= q_mem[q_rd];
      q_rd   <= q_rd + 3'd1;
      q_len  <= q_len - 4'd1;
    end
  end

  // Monitors: cycle count, dequeue pulses, handshake bytes.
  int         cyc    = 0;
  int         deq0_n = 0;
  int         deqt_n = 0;
  int         g_times[$];
  logic [7:0] hs_q[$];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (deq0)  deq0_n <= deq0_n + 1;
    if (deq_t) deqt_n <= deqt_n + 1;
    if (deq_g) g_times.push_back(cyc);
    if (vld0 && ready_in) hs_q.push_back(dout0);
  end

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int n);
    q_load_n = 4'(n);
    q_load   = 1'b1;
    tick();
    q_load   = 1'b0;
  endtask

  int d;
  int h;
  int n0;
  int rem;
  int n;

  initial begin
    reset_n  = 1'b0;
    enable   = 1'b0;
    ready_in = 1'b0;
    q_load   = 1'b0;
    q_load_n = 4'd0;
    len_t    = 4'd0;
    len_g    = 4'd0;
    for (int i = 0; i < 8; i++) q_vals[i] = 8'h00;
    repeat (2) tick();

    check("rst_dequeue", deq0, 1'b0);
    check("rst_valid", vld0, 1'b0);
    check("rst_data", dout0, 8'h00);
    check("rst_busy", busy0, 1'b0);
    check("rst_count", cnt0, 8'h00);
    reset_n = 1'b1;
    tick();

    // Single byte 0xA5: pulse at N, valid at N+2, count 1, no second pulse.
    q_vals[0] = 8'hA5;
    load(1);
    d = deq0_n;
    enable   = 1'b1;
    ready_in = 1'b1;
    tick();
    check("pop_pulse", deq0, 1'b1);
    check("pop_busy", busy0, 1'b1);
    tick();
    check("latch_no_pulse", deq0, 1'b0);
    check("latch_no_valid", vld0, 1'b0);
    tick();
    check("present_valid", vld0, 1'b1);
    check("present_data", dout0, 8'hA5);
    tick();
    check("hs_count1", cnt0, 8'd1);
    check("hs_valid_drop", vld0, 1'b0);
    repeat (8) tick();
    check("single_pulse", 32'(deq0_n - d), 32'd1);

    // Backpressure with three queued bytes.
    ready_in  = 1'b0;
    q_vals[0] = 8'h11;
    q_vals[1] = 8'h22;
    q_vals[2] = 8'h33;
    load(3);
    h = hs_q.size();
    d = deq0_n;
    for (int k = 0; k < 12 && !vld0; k++) tick();
    check("bp_valid_seen", vld0, 1'b1);
    check("bp_first_data", dout0, 8'h11);
    repeat (6) tick();
    check("bp_valid_held", vld0, 1'b1);
    check("bp_data_held", dout0, 8'h11);
    check("bp_no_pulse", 32'(deq0_n - d), 32'd1);
    ready_in = 1'b1;
    repeat (12) tick();
    check("bp_hs_total", 32'(hs_q.size() - h), 32'd3);
    check("bp_byte0", hs_q[h], 8'h11);
    check("bp_byte1", hs_q[h+1], 8'h22);
    check("bp_byte2", hs_q[h+2], 8'h33);
    check("bp_pulses", 32'(deq0_n - d), 32'd3);
    check("bp_count", cnt0, 8'd4);
    check("bp_queue_empty", q_len, 4'd0);

    // Threshold 4: len 3 never pops, len 4 pops next cycle.
    len_t = 4'd3;
    d = deqt_n;
    repeat (20) tick();
    check("thr_below_no_pop", 32'(deqt_n - d), 32'd0);
    check("thr_below_idle", busy_t, 1'b0);
    len_t = 4'd4;
    tick();
    check("thr_at_pop", deq_t, 1'b1);
    len_t = 4'd0;
    repeat (5) tick();
    check("thr_back_idle", busy_t, 1'b0);

    // Gap of 3 idle cycles: pulses 7 cycles apart.
    n0 = g_times.size();
    len_g = 4'd5;
    repeat (24) tick();
    len_g = 4'd0;
    repeat (4) tick();
    check("gap_pulse_cnt", 32'(g_times.size() - n0), 32'd4);
    check("gap_spacing1", 32'(g_times[n0+1] - g_times[n0]), 32'd7);
    check("gap_spacing2", 32'(g_times[n0+2] - g_times[n0+1]), 32'd7);
    check("gap_hs_count", cnt_g, 8'd4);

    // Drive the main counter up to 255 in batches of at most 8 bytes.
    rem = 255 - 4;
    while (rem > 0) begin
      n = (rem > 8) ? 8 : rem;
      for (int i = 0; i < 8; i++) q_vals[i] = 8'(i);
      load(n);
      for (int k = 0; k < 60 && !(q_len == 4'd0 && !busy0); k++) tick();
      check("fill_drained", (q_len == 4'd0 && !busy0), 1'b1);
      rem = rem - n;
    end
    check("wrap_count255", cnt0, 8'd255);

    // Drop enable in LATCH: item still delivered, counter wraps, no new pop.
    q_vals[0] = 8'h5A;
    q_vals[1] = 8'h6B;
    load(2);
    d = deq0_n;
    tick();
    check("en_pop", deq0, 1'b1);
    tick();
    enable = 1'b0;
    check("en_latch", {busy0, deq0, vld0}, 3'b100);
    tick();
    check("en_present_valid", vld0, 1'b1);
    check("en_present_data", dout0, 8'h5A);
    tick();
    check("wrap_count0", cnt0, 8'd0);
    repeat (10) tick();
    check("en_no_more_pulse", 32'(deq0_n - d), 32'd1);
    check("en_queue_left", q_len, 4'd1);
    check("en_idle", busy0, 1'b0);

    // Asynchronous reset while presenting 0x3C.
    enable = 1'b1;
    repeat (6) tick();
    check("pre_rst_count", cnt0, 8'd1);
    ready_in  = 1'b0;
    q_vals[0] = 8'h3C;
    load(1);
    for (int k = 0; k < 12 && !vld0; k++) tick();
    check("ar_valid_seen", vld0, 1'b1);
    check("ar_data_seen", dout0, 8'h3C);
    reset_n = 1'b0;
    #1;
    check("ar_valid_clr", vld0, 1'b0);
    check("ar_data_clr", dout0, 8'h00);
    check("ar_count_clr", cnt0, 8'h00);
    check("ar_busy_clr", busy0, 1'b0);
    load(0);
    reset_n = 1'b1;
    d = deq0_n;
    repeat (5) tick();
    check("ar_stay_idle", busy0, 1'b0);
    check("ar_no_pulse", 32'(deq0_n - d), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
